// File: rtl/needle_heystack_serializer.sv
// Serializes a parallel needle word followed by a byte-wide heystack stream into one framed byte stream.
// Output bytes are registered; ready outputs are combinational from state and enable.
module needle_heystack_serializer #(
    parameter int unsigned STRING_SIZE = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [STRING_SIZE*8-1:0] needle,
    input  logic                     needle_valid,
    output logic                     needle_ready,
    input  logic [7:0]               heystack_data,
    input  logic                     heystack_valid,
    input  logic                     heystack_last,
    output logic                     heystack_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    output logic                     out_last
);

    localparam int unsigned NEEDLE_W = STRING_SIZE * 8;
    localparam int unsigned IDX_W    = $clog2(STRING_SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE          = 2'd0,
        S_SEND_NEEDLE   = 2'd1,
        S_SEND_HEYSTACK = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NEEDLE_W-1:0] r_needle;
    logic [NEEDLE_W-1:0] w_needle_nxt;
    logic [IDX_W-1:0]    r_index;
    logic [IDX_W-1:0]    w_index_nxt;
    logic [7:0]          r_out_data;
    logic [7:0]          w_out_data_nxt;
    logic                r_out_valid;
    logic                w_out_valid_nxt;
    logic                r_out_last;
    logic                w_out_last_nxt;
    logic [7:0]          w_needle_byte;

    assign needle_ready   = enable && (r_state == S_IDLE);
    assign heystack_ready = enable && (r_state == S_SEND_HEYSTACK);

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

    // Select needle byte r_index from the captured word
    always_comb begin
        w_needle_byte = '0;
        for (int unsigned i = 0; i < STRING_SIZE; i++) begin
            if (r_index == IDX_W'(i)) begin
                w_needle_byte = r_needle[i*8 +: 8];
            end
        end
    end

    // Next-state and output-byte logic
    always_comb begin
        w_state_nxt     = r_state;
        w_needle_nxt    = r_needle;
        w_index_nxt     = r_index;
        w_out_data_nxt  = 8'h00;
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (needle_valid && needle_ready) begin
                    w_needle_nxt = needle;
                    w_index_nxt  = '0;
                    w_state_nxt  = S_SEND_NEEDLE;
                end
            end
            S_SEND_NEEDLE: begin
                if (enable) begin
                    w_out_data_nxt  = w_needle_byte;
                    w_out_valid_nxt = 1'b1;
                    if (r_index == IDX_W'(STRING_SIZE - 1)) begin
                        w_index_nxt = '0;
                        w_state_nxt = S_SEND_HEYSTACK;
                    end else begin
                        w_index_nxt = r_index + IDX_W'(1);
                    end
                end
            end
            S_SEND_HEYSTACK: begin
                if (heystack_valid && heystack_ready) begin
                    w_out_data_nxt  = heystack_data;
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = heystack_last;
                    if (heystack_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_needle    <= '0;
            r_index     <= '0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_needle    <= w_needle_nxt;
            r_index     <= w_index_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

endmodule

// File: tb/tb_needle_heystack_serializer.sv
// Self-checking bench for needle_heystack_serializer: a vector table, scripted corner cases
// and randomized traffic checked against a queue-based frame model.
module tb_needle_heystack_serializer;

    localparam int unsigned SS = 5;
    localparam logic [39:0] HELLO = 40'h6F6C6C6568;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [SS*8-1:0] needle;
    logic          needle_valid;
    logic          needle_ready;
    logic [7:0]    heystack_data;
    logic          heystack_valid;
    logic          heystack_last;
    logic          heystack_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_last;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: bytes still owed from the captured needle, and whether heystack is open
    logic [7:0] m_q[$];
    bit         m_hay = 1'b0;

    needle_heystack_serializer #(.STRING_SIZE(SS)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .needle         (needle),
        .needle_valid   (needle_valid),
        .needle_ready   (needle_ready),
        .heystack_data  (heystack_data),
        .heystack_valid (heystack_valid),
        .heystack_last  (heystack_last),
        .heystack_ready (heystack_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_last       (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        en;
        logic        nv;
        logic [39:0] nd;
        logic        hv;
        logic [7:0]  hd;
        logic        hl;
        logic        e_nr;
        logic        e_hr;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ol;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit en, input bit nv, input logic [39:0] nd,
                         input bit hv, input logic [7:0] hd, input bit hl);
        reset          = rst;
        enable         = en;
        needle_valid   = nv;
        needle         = nd;
        heystack_valid = hv;
        heystack_data  = hd;
        heystack_last  = hl;
    endtask

    // One model-checked cycle; entered and left 1 time unit after a rising edge
    task automatic run_cycle(input string tag, input bit rst, input bit en, input bit nv,
                             input logic [39:0] nd, input bit hv, input logic [7:0] hd, input bit hl);
        bit         e_nr;
        bit         e_hr;
        bit         e_ov;
        logic [7:0] e_od;
        bit         e_ol;
        drive(rst, en, nv, nd, hv, hd, hl);
        #1;
        e_nr = en && !m_hay && (m_q.size() == 0);
        e_hr = en && m_hay;
        chk({tag, "_needle_ready"}, 64'(needle_ready), 64'(e_nr));
        chk({tag, "_heystack_ready"}, 64'(heystack_ready), 64'(e_hr));
        e_ov = 1'b0;
        e_od = 8'h00;
        e_ol = 1'b0;
        if (rst) begin
            m_q.delete();
            m_hay = 1'b0;
        end else if (en) begin
            if (m_q.size() > 0) begin
                e_ov = 1'b1;
                e_od = m_q.pop_front();
                if (m_q.size() == 0) m_hay = 1'b1;
            end else if (m_hay) begin
                if (hv) begin
                    e_ov = 1'b1;
                    e_od = hd;
                    e_ol = hl;
                    if (hl) m_hay = 1'b0;
                end
            end else if (nv) begin
                for (int k = 0; k < int'(SS); k++) m_q.push_back(nd[k*8 +: 8]);
            end
        end
        @(posedge clock);
        #1;
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(e_ov));
        chk({tag, "_out_data"}, 64'(out_data), 64'(e_od));
        chk({tag, "_out_last"}, 64'(out_last), 64'(e_ol));
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) run_cycle(tag, 1'b0, 1'b1, 1'b0, 40'h0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [63:0] r64;
        bit          en;
        bit          nv;
        bit          hv;
        bit          hl;
        bit          rst;
        logic [7:0]  hd;

        // Needle "hello" with heystack 'a' offered from the accept cycle, then 'b'+last
        tbl[0] = '{1'b1, 1'b1, HELLO, 1'b1, 8'h61, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 40'h0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b1, 8'h68, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 40'h0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b1, 8'h65, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 40'h0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b1, 8'h6C, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 40'h0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b1, 8'h6C, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 40'h0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b1, 8'h6F, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 40'h0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b1, 1'b1, 8'h61, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 40'h0, 1'b1, 8'h62, 1'b1, 1'b0, 1'b1, 1'b1, 8'h62, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 40'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        drive(1'b1, 1'b1, 1'b0, 40'h0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_needle_ready", 64'(needle_ready), 64'd1);
        chk("rst_heystack_ready", 64'(heystack_ready), 64'd0);

        for (int i = 0; i < 9; i++) begin
            drive(1'b0, tbl[i].en, tbl[i].nv, tbl[i].nd, tbl[i].hv, tbl[i].hd, tbl[i].hl);
            #1;
            chk($sformatf("tbl%0d_needle_ready", i), 64'(needle_ready), 64'(tbl[i].e_nr));
            chk($sformatf("tbl%0d_heystack_ready", i), 64'(heystack_ready), 64'(tbl[i].e_hr));
            @(posedge clock);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_data", i), 64'(out_data), 64'(tbl[i].e_od));
            chk($sformatf("tbl%0d_out_last", i), 64'(out_last), 64'(tbl[i].e_ol));
        end

        // Heystack valid toggling 1,0,0,1 leaves matching gaps
        run_cycle("t3", 1'b1, 1'b1, 1'b0, 40'h0, 1'b0, 8'h00, 1'b0);
        run_cycle("t3", 1'b0, 1'b1, 1'b1, HELLO, 1'b0, 8'h00, 1'b0);
        idle_cycles("t3", 5);
        run_cycle("t3", 1'b0, 1'b1, 1'b0, 40'h0, 1'b1, 8'h41, 1'b0);
        chk("t3_first", 64'({out_valid, out_data}), 64'({1'b1, 8'h41}));
        run_cycle("t3", 1'b0, 1'b1, 1'b0, 40'h0, 1'b0, 8'h42, 1'b0);
        chk("t3_gap1", 64'(out_valid), 64'd0);
        run_cycle("t3", 1'b0, 1'b1, 1'b0, 40'h0, 1'b0, 8'h42, 1'b0);
        chk("t3_gap2", 64'(out_valid), 64'd0);
        run_cycle("t3", 1'b0, 1'b1, 1'b0, 40'h0, 1'b1, 8'h42, 1'b1);
        chk("t3_second", 64'({out_valid, out_data, out_last}), 64'({1'b1, 8'h42, 1'b1}));

        // Enable low for 3 cycles after the 2nd needle byte
        run_cycle("t4", 1'b0, 1'b1, 1'b1, HELLO, 1'b0, 8'h00, 1'b0);
        idle_cycles("t4", 2);
        chk("t4_second_byte", 64'(out_data), 64'h65);
        for (int k = 0; k < 3; k++) begin
            run_cycle("t4", 1'b0, 1'b0, 1'b1, 40'h0, 1'b1, 8'h77, 1'b0);
            chk("t4_stalled", 64'(out_valid), 64'd0);
        end
        run_cycle("t4", 1'b0, 1'b1, 1'b0, 40'h0, 1'b0, 8'h00, 1'b0);
        chk("t4_resume0", 64'(out_data), 64'h6C);
        run_cycle("t4", 1'b0, 1'b1, 1'b0, 40'h0, 1'b0, 8'h00, 1'b0);
        chk("t4_resume1", 64'(out_data), 64'h6C);
        run_cycle("t4", 1'b0, 1'b1, 1'b0, 40'h0, 1'b0, 8'h00, 1'b0);
        chk("t4_resume2", 64'(out_data), 64'h6F);

        // Reset while heystack byte 2 is being accepted
        run_cycle("t5", 1'b0, 1'b1, 1'b0, 40'h0, 1'b1, 8'h61, 1'b0);
        run_cycle("t5", 1'b1, 1'b1, 1'b0, 40'h0, 1'b1, 8'h62, 1'b0);
        chk("t5_out_zero", 64'({out_valid, out_data, out_last}), 64'd0);
        chk("t5_needle_ready", 64'(needle_ready), 64'd1);
        chk("t5_heystack_ready", 64'(heystack_ready), 64'd0);

        // Second needle offered alongside first frame's last byte
        run_cycle("t6", 1'b0, 1'b1, 1'b1, HELLO, 1'b0, 8'h00, 1'b0);
        idle_cycles("t6", 5);
        run_cycle("t6", 1'b0, 1'b1, 1'b1, 40'h1122334455, 1'b1, 8'h7A, 1'b1);
        chk("t6_last", 64'({out_data, out_last}), 64'({8'h7A, 1'b1}));
        run_cycle("t6", 1'b0, 1'b1, 1'b1, 40'h1122334455, 1'b0, 8'h00, 1'b0);
        chk("t6_bubble", 64'(out_valid), 64'd0);
        run_cycle("t6", 1'b0, 1'b1, 1'b0, 40'h0, 1'b0, 8'h00, 1'b0);
        chk("t6_second_frame", 64'({out_valid, out_data}), 64'({1'b1, 8'h55}));
        idle_cycles("t6", 4);

        // Randomized traffic against the frame model
        for (int c = 0; c < 3000; c++) begin
            r64 = {$urandom(), $urandom()};
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 7) != 0);
            nv  = ($urandom_range(0, 3) != 0);
            hv  = ($urandom_range(0, 9) < 6);
            hd  = 8'($urandom_range(0, 255));
            hl  = ($urandom_range(0, 3) == 0);
            run_cycle("rnd", rst, en, nv, r64[39:0], hv, hd, hl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
